// File: rtl/proc_pkg.sv
// Shared datapath types and widths for the register-file write side.
package proc_pkg;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/writeback_unit_if.sv
// Result handshake from execute/memory plus the register-file write port.
interface writeback_unit_if;
    import proc_pkg::*;

    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_alu;
    logic [DW-1:0] res_mem;
    logic          res_memtoreg;
    logic [AW-1:0] res_rt;
    logic [AW-1:0] res_rd;
    logic          res_regdest;
    logic          res_regwrite;
    logic          rf_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    modport master (
        output res_valid, res_alu, res_mem, res_memtoreg, res_rt, res_rd,
               res_regdest, res_regwrite, rf_ready,
        input  res_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  res_valid, res_alu, res_mem, res_memtoreg, res_rt, res_rd,
               res_regdest, res_regwrite, rf_ready,
        output res_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/wb_fifo.sv
// In-order write queue; exposes every slot oldest-first for the lookup scan.
module wb_fifo
    import proc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  wb_entry_t              wr_entry,
    output wb_entry_t              head,
    output logic [$clog2(DEPTH):0] count,
    output wb_entry_t              entries [DEPTH],
    output logic [DEPTH-1:0]       valid
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    assign head = mem[rd_ptr];

    // Slot i of the view is the i-th oldest entry.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[i] = mem[rd_ptr + PW'(i)];
            valid[i]   = CW'(i) < count;
        end
    end
endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback: source/destination muxing, r0 drop filter and queueing.
// Optional pending-value lookup is built when WB_FORWARD_EN is defined.
module writeback_unit
    import proc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    writeback_unit_if.slave        wb,
    input  logic                   flush,
    input  logic [AW-1:0]          fwd_addr,
    output logic                   fwd_hit,
    output logic [DW-1:0]          fwd_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wb_entry_t        new_entry;
    wb_entry_t        head;
    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             accept;
    logic             push;
    logic             pop;

    assign new_entry.addr = wb.res_regdest  ? wb.res_rd  : wb.res_rt;
    assign new_entry.data = wb.res_memtoreg ? wb.res_mem : wb.res_alu;

    // Ready looks only at the registered count, so a full queue never accepts on a pop.
    assign wb.res_ready = count < CW'(DEPTH);
    assign accept       = wb.res_valid && wb.res_ready;
    assign push         = accept && wb.res_regwrite && (new_entry.addr != REG_ZERO);
    assign pop          = wb.wr_en && wb.rf_ready;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_entry (new_entry),
        .head     (head),
        .count    (count),
        .entries  (entries),
        .valid    (valid)
    );

    assign wb.wr_en   = count != '0;
    assign wb.wr_addr = wb.wr_en ? head.addr : '0;
    assign wb.wr_data = wb.wr_en ? head.data : '0;

`ifdef WB_FORWARD_EN
    // Oldest to youngest, so the last match is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].addr == fwd_addr) && (fwd_addr != REG_ZERO)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[i].data;
            end
        end
    end
`else
    logic [DEPTH-1:0] unused_scan;
    logic             unused_addr;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) unused_scan[i] = valid[i] ^ (^entries[i]);
    end

    assign unused_addr = ^fwd_addr;
    assign fwd_hit     = 1'b0;
    assign fwd_data    = '0;
`endif
endmodule
